// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types, response codes and arbiter state encoding.
package axi_lite_pkg;
    typedef logic [11:0] addr_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int ARB_MAX_M = 8;
    typedef enum logic [1:0] {IDLE, READ, WRITE} arb_state_t;
endpackage

// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_arbiter_if: N-port AXI4-Lite bundle; master drives requests, slave drives responses.
interface axi_lite_arbiter_if #(
    parameter int N = 1,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [N-1:0] awvalid, awready, wvalid, wready, bvalid, bready;
    logic [N-1:0] arvalid, arready, rvalid, rready;
    logic [N*ADDR_W-1:0] awaddr, araddr;
    logic [N*DATA_W-1:0] wdata, rdata;
    logic [N*2-1:0] bresp, rresp;
    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_rr_pick.sv
// axi_lite_rr_pick: picks the next requester after last (round-robin); with
// AXI_LITE_ARB_FIXED_PRIO_EN defined the lowest requesting index always wins.
module axi_lite_rr_pick
    import axi_lite_pkg::*;
#(
    parameter int N = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          valid
);
    assign valid = |req;
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
    // Scan downward so the lowest requesting index is the final assignment.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) if (req[k]) pick = IW'(k);
    end
`else
    logic [IW-1:0] j;
    // Scan from the farthest offset back to last+1 so the nearest requester wins.
    always_comb begin
        pick = '0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N);
            if (req[j]) pick = j;
        end
    end
`endif
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI4-Lite slave between NUM_M masters, one transaction at a time.
// Define AXI_LITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input logic aclk,
    input logic areset,
    axi_lite_arbiter_if.slave m,
    axi_lite_arbiter_if.master s
);
    localparam int IW = $clog2(NUM_M);
    if (NUM_M < 2 || NUM_M > ARB_MAX_M) begin : g_num_m_chk
        $error("NUM_M out of range");
    end
    arb_state_t state, state_n;
    logic [IW-1:0] gnt, gnt_n, last, last_n, pick;
    logic aw_done, aw_done_n, w_done, w_done_n, pick_vld;
    logic [NUM_M-1:0] req;
    assign req = m.arvalid | m.awvalid;
    axi_lite_rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
        .req(req),
        .last(last),
        .pick(pick),
        .valid(pick_vld)
    );
    // State, grant and round-robin registers; reset abandons any in-flight transaction.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            gnt <= '0;
            last <= IW'(NUM_M - 1);
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            last <= last_n;
            aw_done <= aw_done_n;
            w_done <= w_done_n;
        end
    end
    // Next-state logic plus combinational routing of the granted master's channels.
    always_comb begin
        state_n = state;
        gnt_n = gnt;
        last_n = last;
        aw_done_n = aw_done;
        w_done_n = w_done;
        s.awvalid = '0;
        s.awaddr = '0;
        s.wvalid = '0;
        s.wdata = '0;
        s.bready = '0;
        s.arvalid = '0;
        s.araddr = '0;
        s.rready = '0;
        m.awready = '0;
        m.wready = '0;
        m.bvalid = '0;
        m.bresp = '0;
        m.arready = '0;
        m.rvalid = '0;
        m.rdata = '0;
        m.rresp = '0;
        case (state)
            IDLE: if (pick_vld) begin
                state_n = m.arvalid[pick] ? READ : WRITE;
                gnt_n = pick;
                last_n = pick;
                aw_done_n = 1'b0;
                w_done_n = 1'b0;
            end
            READ: begin
                s.arvalid = m.arvalid[gnt];
                s.araddr = m.araddr[gnt*ADDR_W +: ADDR_W];
                s.rready = m.rready[gnt];
                m.arready[gnt] = s.arready;
                m.rvalid[gnt] = s.rvalid;
                m.rdata[gnt*DATA_W +: DATA_W] = s.rdata;
                m.rresp[gnt*2 +: 2] = s.rresp;
                state_n = (s.rvalid & s.rready) ? IDLE : READ;
            end
            WRITE: begin
                s.awvalid = m.awvalid[gnt] & ~aw_done;
                s.awaddr = m.awaddr[gnt*ADDR_W +: ADDR_W];
                s.wvalid = m.wvalid[gnt] & ~w_done;
                s.wdata = m.wdata[gnt*DATA_W +: DATA_W];
                s.bready = m.bready[gnt];
                m.awready[gnt] = s.awready & ~aw_done;
                m.wready[gnt] = s.wready & ~w_done;
                m.bvalid[gnt] = s.bvalid;
                m.bresp[gnt*2 +: 2] = s.bresp;
                aw_done_n = aw_done | (s.awvalid & s.awready);
                w_done_n = w_done | (s.wvalid & s.wready);
                state_n = (s.bvalid & s.bready) ? IDLE : WRITE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed checks of arbitration order, routing, masking and reset.
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int m1_act = 0;
    int done_q[$];
    logic [31:0] mem [0:1023];
    logic aw_got, w_got;
    addr_t waddr;
    logic [31:0] wbuf;
    logic s_any, m_any;
    axi_lite_arbiter_if #(.N(2)) mi();
    axi_lite_arbiter_if #(.N(1)) si();
    axi_lite_arbiter #(.NUM_M(2)) dut (
        .aclk(aclk),
        .areset(areset),
        .m(mi),
        .s(si)
    );
    always #5 aclk = ~aclk;
    assign s_any = |{si.awvalid, si.awaddr, si.wvalid, si.wdata, si.bready, si.arvalid, si.araddr, si.rready};
    assign m_any = |{mi.awready, mi.wready, mi.bvalid, mi.bresp, mi.arready, mi.rvalid, mi.rdata, mi.rresp};
    // Single-outstanding slave model; addresses with bit 11 set answer SLVERR.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[4] <= 32'hDEADBEEF;
            si.arready <= '0;
            si.rvalid <= '0;
            si.rdata <= '0;
            si.rresp <= '0;
            si.awready <= '0;
            si.wready <= '0;
            si.bvalid <= '0;
            si.bresp <= '0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            waddr <= '0;
            wbuf <= '0;
        end else begin
            si.arready <= si.arvalid & ~si.arready & ~si.rvalid;
            if (si.arvalid[0] && si.arready[0]) begin
                si.rvalid <= 1'b1;
                si.rdata <= mem[si.araddr[11:2]];
                si.rresp <= si.araddr[11] ? 2'b10 : RESP_OKAY;
            end else if (si.rvalid[0] && si.rready[0]) si.rvalid <= 1'b0;
            si.awready <= si.awvalid & ~si.awready & ~aw_got & ~si.bvalid;
            si.wready <= si.wvalid & ~si.wready & ~w_got & ~si.bvalid;
            if (si.awvalid[0] && si.awready[0]) begin
                aw_got <= 1'b1;
                waddr <= si.awaddr;
            end
            if (si.wvalid[0] && si.wready[0]) begin
                w_got <= 1'b1;
                wbuf <= si.wdata;
            end
            if (aw_got && w_got && !si.bvalid[0]) begin
                si.bvalid <= 1'b1;
                mem[waddr[11:2]] <= wbuf;
                si.bresp <= waddr[11] ? 2'b10 : RESP_OKAY;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end else if (si.bvalid[0] && si.bready[0]) si.bvalid <= 1'b0;
        end
    end
    // Count cycles where the slave sees both requests or master 1 sees any output.
    always @(negedge aclk) begin
        if (si.arvalid[0] && si.awvalid[0]) overlap++;
        if (|{mi.arready[1], mi.rvalid[1], mi.awready[1], mi.wready[1], mi.bvalid[1],
              mi.rdata[63:32], mi.rresp[3:2], mi.bresp[3:2]}) m1_act++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int i, input addr_t a, input logic [31:0] d, output logic [1:0] resp);
        bit aw_hs, w_hs, b_hs;
        bit fin = 0;
        resp = 2'b11;
        mi.awvalid[i] = 1'b1;
        mi.awaddr[i*12 +: 12] = a;
        mi.wvalid[i] = 1'b1;
        mi.wdata[i*32 +: 32] = d;
        mi.bready[i] = 1'b1;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge aclk);
            aw_hs = mi.awvalid[i] & mi.awready[i];
            w_hs = mi.wvalid[i] & mi.wready[i];
            b_hs = mi.bvalid[i] & mi.bready[i];
            if (b_hs) resp = mi.bresp[i*2 +: 2];
            @(posedge aclk);
            #1;
            if (aw_hs) mi.awvalid[i] = 1'b0;
            if (w_hs) mi.wvalid[i] = 1'b0;
            if (b_hs) begin
                mi.bready[i] = 1'b0;
                done_q.push_back(16 + i);
                fin = 1;
            end
        end
        if (!fin) check("wr_timeout", 0, 1);
    endtask

    task automatic rd(input int i, input addr_t a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_hs, r_hs;
        bit fin = 0;
        d = '0;
        resp = 2'b11;
        mi.arvalid[i] = 1'b1;
        mi.araddr[i*12 +: 12] = a;
        mi.rready[i] = 1'b1;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge aclk);
            ar_hs = mi.arvalid[i] & mi.arready[i];
            r_hs = mi.rvalid[i] & mi.rready[i];
            if (r_hs) begin
                d = mi.rdata[i*32 +: 32];
                resp = mi.rresp[i*2 +: 2];
            end
            @(posedge aclk);
            #1;
            if (ar_hs) mi.arvalid[i] = 1'b0;
            if (r_hs) begin
                mi.rready[i] = 1'b0;
                done_q.push_back(i);
                fin = 1;
            end
        end
        if (!fin) check("rd_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [1:0] r0, r1;
        int act0;
        bit hs;
        int exp_q[4];
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
        exp_q = '{16, 16, 17, 17};
`else
        exp_q = '{16, 17, 16, 17};
`endif
        mi.awvalid = '0; mi.awaddr = '0; mi.wvalid = '0; mi.wdata = '0;
        mi.bready = '0; mi.arvalid = '0; mi.araddr = '0; mi.rready = '0;
        repeat (3) @(posedge aclk);
        check("rst_s_idle", s_any, 0);
        check("rst_m_idle", m_any, 0);
        #1 areset = 1'b0;
        fork
            begin wr(0, 12'h100, 32'h11110000, r0); wr(0, 12'h104, 32'h11110004, r0); end
            begin wr(1, 12'h200, 32'h22220000, r1); wr(1, 12'h204, 32'h22220004, r1); end
        join
        check("cont_n", done_q.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), done_q[k], exp_q[k]);
        check("cont_bresp", {r0, r1}, 4'b0000);
        done_q.delete();
        @(posedge aclk);
        #1;
        act0 = m1_act;
        mi.arvalid[0] = 1'b1;
        mi.araddr[11:0] = 12'h010;
        mi.rready[0] = 1'b1;
        #1 check("ar_not_yet", si.arvalid, 0);
        @(posedge aclk);
        #1;
        check("ar_fwd", si.arvalid, 1);
        check("ar_addr", si.araddr, 12'h010);
        rd(0, 12'h010, d0, r0);
        check("rd0_data", d0, 32'hDEADBEEF);
        check("rd0_resp", r0, RESP_OKAY);
        check("m1_quiet", m1_act - act0, 0);
        wr(1, 12'h0A5, 32'h12345678, r1);
        check("wr1_bresp", r1, RESP_OKAY);
        rd(1, 12'h0A5, d1, r1);
        check("rb1_data", d1, 32'h12345678);
        check("rb1_resp", r1, RESP_OKAY);
        rd(1, 12'h204, d1, r1);
        check("rb_cont", d1, 32'h22220004);
        rd(0, 12'h900, d0, r0);
        check("err_resp", r0, 2'b10);
        check("err_data", d0, 0);
        done_q.delete();
        fork
            rd(1, 12'h100, d1, r1);
            wr(1, 12'h0B0, 32'hCAFEF00D, r0);
        join
        check("rw_first", done_q[0], 1);
        check("rw_second", done_q[1], 17);
        check("rw_data", d1, 32'h11110000);
        check("no_overlap", overlap, 0);
        @(posedge aclk);
        #1;
        mi.awvalid[0] = 1'b1;
        mi.awaddr[11:0] = 12'h300;
        mi.wdata[31:0] = 32'h55AA55AA;
        mi.bready[0] = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge aclk);
            hs = mi.awvalid[0] & mi.awready[0];
        end
        if (!hs) check("aw_timeout", 0, 1);
        @(posedge aclk);
        #1 mi.awvalid[0] = 1'b0;
        @(negedge aclk);
        check("pre_rst_bready", si.bready, 1);
        check("pre_rst_awaddr", si.awaddr, 12'h300);
        #1 areset = 1'b1;
        #1;
        check("mid_rst_s", s_any, 0);
        check("mid_rst_m", m_any, 0);
        mi.bready = '0; mi.awaddr = '0; mi.wdata = '0;
        @(posedge aclk);
        #1 areset = 1'b0;
        done_q.delete();
        fork
            rd(0, 12'h010, d0, r0);
            rd(1, 12'h0A4, d1, r1);
        join
        check("post_rst_first", done_q[0], 0);
        check("post_rst_second", done_q[1], 1);
        check("post_rst_data", d0, 32'hDEADBEEF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
